i_imm_sequencer: RTL
====================

# i_imm_sequencer

Parametrised, clocked successor to the single-cycle I-format arithmetic decoder. It decodes all LEGv8 immediate-class instructions: ADDI/ADDIS/SUBI/SUBIS, ANDI/ANDIS/ORRI/EORI, MOVZ and MOVK. For each accepted instruction it emits one or two registered 29-bit control words plus the K constant. It sits between the fetch/dispatch stage and the datapath control mux, in the same slot as the other format decoders.

## Interface
- `DATA_WIDTH`, 64: width of K and of the datapath; must be 32 or 64.
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-low.
- `instruction`, in, 32: instruction word; sampled on acceptance.
- `instr_valid`, in, 1: instruction present.
- `instr_ready`, out, 1: block can accept.
- `controlWord`, out, 29: {Psel[1:0], DA[4:0], SA[4:0], SB[4:0], Fsel[4:0], regW, ramW, Dsel[1:0], Bsel, PCsel, SL}.
- `K`, out, DATA_WIDTH: immediate operand for the B side.
- `cw_valid`, out, 1: `controlWord`/`K` valid this cycle.
- `illegal`, out, 1: one-cycle pulse for an undecodable or out-of-range instruction.
- `state`, out, 2: current FSM state, for the observability of the top-level sequencer.

## Operation
- Acceptance: `instr_valid & instr_ready` at a rising edge.
- `instr_ready` = reset deasserted and state ≠ MOVK_MASK. Back-to-back single-step instructions issue at one per cycle.
- FSM states: IDLE=2'b00, EXEC=2'b01, MOVK_MASK=2'b10.
  - Any state, accept of a non-MOVK instruction -> EXEC.
  - Accept of a valid MOVK -> MOVK_MASK.
  - MOVK_MASK -> EXEC unconditionally.
  - EXEC with no accept -> IDLE.
- Common fields:
  - SB=0, ramW=0, Dsel=01, Bsel=1, PCsel=0.
  - DA=instr[4:0].
  - Psel=01 on the final step of an instruction; Psel=00 on MOVK_MASK.
- Arithmetic (opcode bits[31:22]: 1001000100, 1011000100, 1101000100, 1111000100):
  - SA=instr[9:5], K=zero-extended instr[21:10].
  - Fsel=ADD (01000) or SUB (01001).
  - SL = S-variant, regW=1.
- Logical (bits[31:22]: ANDI 1001001000, ANDIS 1111001000, ORRI 1011001000, EORI 1101001000):
  - SA=instr[9:5], K=zero-extended imm12.
  - Fsel AND=00000, ORR=00100, EOR=01100.
  - SL=1 only for ANDIS.
- MOVZ (bits[31:23]=110100101):
  - SA=31 (XZR), Fsel=ORR.
  - K = imm16 << (16·hw), where hw=instr[22:21] and imm16=instr[20:5].
  - SL=0, regW=1.
- MOVK (bits[31:23]=111100101), two steps:
  - MOVK_MASK: SA=DA=Rd, Fsel=AND, K = ~(16'hFFFF << 16·hw), regW=1, SL=0.
  - EXEC: SA=DA=Rd, Fsel=ORR, K = imm16 << 16·hw, regW=1.
- Range rule: hw ≥ DATA_WIDTH/16 (hw ≥ 2 when DATA_WIDTH=32) is illegal.
- Illegal handling: unknown opcode or out-of-range hw -> `illegal`=1 and `cw_valid`=0 for one cycle; state -> IDLE; no register write.

## Timing
- Latency: instruction accepted at edge t -> its control word is valid from t through t+1. MOVK occupies two consecutive `cw_valid` cycles.
- All outputs except `instr_ready` are registered.
- Reset values: `controlWord`=0, `K`=0, `cw_valid`=0, `illegal`=0, `state`=IDLE, `instr_ready`=0 while reset is low.
- Reset asserted mid-MOVK: the MERGE step is abandoned. No further `cw_valid` appears until a new accept.
- `instr_valid` high during MOVK_MASK: not accepted; the instruction must be held until `instr_ready` returns.
- `instr_valid` low in EXEC: the next cycle is IDLE with `cw_valid`=0 and `controlWord` zeroed.

## Structure
- Package `imm_pkg`:
  - Fsel constants.
  - Opcode constants (10-bit and 9-bit).
  - State encoding.
  - Control-word field widths and the NOP control word.
- Sub-module `i_imm_decode`: purely combinational. Maps (instruction, step) to {controlWord, K, is_movk, illegal}.
- Top-level FSM and output registers live in `i_imm_sequencer`.

## Test plan
- ADDI X1,X2,#5 (0x91001441) -> one cycle with:
  - Psel=01, DA=1, SA=2, Fsel=01000, regW=1, Dsel=01, Bsel=1, SL=0.
  - K=5.
- SUBIS X3,X3,#0xFFF (0xF13FFC63) -> Fsel=01001, SL=1, K=0xFFF.
- MOVK X9,#0xBEEF,LSL#32 (0xF2D7DDE9) -> two cycles:
  - Cycle 1: AND, DA=SA=9, Psel=00, K=0xFFFF0000FFFFFFFF; `instr_ready`=0.
  - Cycle 2: ORR, Psel=01, K=0x0000BEEF00000000.
- DATA_WIDTH=32, MOVZ hw=2 -> `illegal` pulse, `cw_valid`=0, state=IDLE.
- Reset low in the MOVK_MASK cycle -> next cycle all outputs 0, no ORR step.
- ADDI, ORRI, ADDIS on consecutive cycles with `instr_valid` held high -> three consecutive `cw_valid` cycles in order, `instr_ready` constantly 1.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared constants for the immediate-class decoder: ALU function selects,
// opcodes, FSM encoding and control-word packing.
package imm_pkg;

  // Control-word geometry
  localparam int CW_W   = 29;
  localparam int PSEL_W = 2;
  localparam int REG_W  = 5;
  localparam int FSEL_W = 5;
  localparam int DSEL_W = 2;

  localparam logic [CW_W-1:0] CW_NOP = '0;

  // ALU function selects
  localparam logic [FSEL_W-1:0] FSEL_AND = 5'b00000;
  localparam logic [FSEL_W-1:0] FSEL_ORR = 5'b00100;
  localparam logic [FSEL_W-1:0] FSEL_EOR = 5'b01100;
  localparam logic [FSEL_W-1:0] FSEL_ADD = 5'b01000;
  localparam logic [FSEL_W-1:0] FSEL_SUB = 5'b01001;

  // 10-bit opcodes, instruction bits [31:22]
  localparam logic [9:0] OP_ADDI  = 10'b1001000100;
  localparam logic [9:0] OP_ADDIS = 10'b1011000100;
  localparam logic [9:0] OP_SUBI  = 10'b1101000100;
  localparam logic [9:0] OP_SUBIS = 10'b1111000100;
  localparam logic [9:0] OP_ANDI  = 10'b1001001000;
  localparam logic [9:0] OP_ANDIS = 10'b1111001000;
  localparam logic [9:0] OP_ORRI  = 10'b1011001000;
  localparam logic [9:0] OP_EORI  = 10'b1101001000;

  // 9-bit wide-move opcodes, instruction bits [31:23]
  localparam logic [8:0] OP9_MOVZ = 9'b110100101;
  localparam logic [8:0] OP9_MOVK = 9'b111100101;

  // Fixed field values
  localparam logic [PSEL_W-1:0] PSEL_HOLD  = 2'b00;
  localparam logic [PSEL_W-1:0] PSEL_FINAL = 2'b01;
  localparam logic [DSEL_W-1:0] DSEL_ALU   = 2'b01;
  localparam logic [REG_W-1:0]  XZR        = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_EXEC      = 2'b01,
    ST_MOVK_MASK = 2'b10
  } state_t;

  // Pack the variable fields; SB, ramW, Dsel, Bsel and PCsel are constant
  // for every immediate-class instruction.
  function automatic logic [CW_W-1:0] make_cw(
    input logic [PSEL_W-1:0] psel,
    input logic [REG_W-1:0]  da,
    input logic [REG_W-1:0]  sa,
    input logic [FSEL_W-1:0] fsel,
    input logic              regw,
    input logic              sl
  );
    return {psel, da, sa, {REG_W{1'b0}}, fsel, regw, 1'b0, DSEL_ALU, 1'b1, 1'b0, sl};
  endfunction

endpackage

// File: rtl/i_imm_decode.sv
// Combinational decode of one immediate-class instruction step into a
// control word and K. step=0 is the first (or only) step; step=1 is the
// MOVK merge step.
module i_imm_decode
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [31:0]           instruction,
  input  logic                  step,
  output logic [CW_W-1:0]       controlWord,
  output logic [DATA_WIDTH-1:0] K,
  output logic                  is_movk,
  output logic                  illegal
);

  logic [9:0]            w_op10;
  logic [8:0]            w_op9;
  logic [REG_W-1:0]      w_rd;
  logic [REG_W-1:0]      w_rn;
  logic [1:0]            w_hw;
  logic [5:0]            w_shamt;
  logic                  w_hw_bad;
  logic [DATA_WIDTH-1:0] w_imm12_ext;
  logic [DATA_WIDTH-1:0] w_imm16_sh;
  logic [DATA_WIDTH-1:0] w_mask;

  assign w_op10      = instruction[31:22];
  assign w_op9       = instruction[31:23];
  assign w_rd        = instruction[4:0];
  assign w_rn        = instruction[9:5];
  assign w_hw        = instruction[22:21];
  assign w_shamt     = {w_hw, 4'b0000};
  // Only a 32-bit datapath can have a halfword slot that does not exist.
  assign w_hw_bad    = (DATA_WIDTH == 32) && w_hw[1];
  assign w_imm12_ext = DATA_WIDTH'(instruction[21:10]);
  assign w_imm16_sh  = DATA_WIDTH'(instruction[20:5]) << w_shamt;
  assign w_mask      = ~(DATA_WIDTH'(16'hFFFF) << w_shamt);

  // Opcode decode; anything unrecognised falls through as illegal with a NOP word
  always_comb begin
    controlWord = CW_NOP;
    K           = '0;
    is_movk     = 1'b0;
    illegal     = 1'b0;
    if (w_op9 == OP9_MOVZ) begin
      if (w_hw_bad) begin
        illegal = 1'b1;
      end else begin
        controlWord = make_cw(PSEL_FINAL, w_rd, XZR, FSEL_ORR, 1'b1, 1'b0);
        K           = w_imm16_sh;
      end
    end else if (w_op9 == OP9_MOVK) begin
      if (w_hw_bad) begin
        illegal = 1'b1;
      end else begin
        is_movk = 1'b1;
        if (!step) begin
          controlWord = make_cw(PSEL_HOLD, w_rd, w_rd, FSEL_AND, 1'b1, 1'b0);
          K           = w_mask;
        end else begin
          controlWord = make_cw(PSEL_FINAL, w_rd, w_rd, FSEL_ORR, 1'b1, 1'b0);
          K           = w_imm16_sh;
        end
      end
    end else begin
      K = w_imm12_ext;
      case (w_op10)
        OP_ADDI:  controlWord = make_cw(PSEL_FINAL, w_rd, w_rn, FSEL_ADD, 1'b1, 1'b0);
        OP_ADDIS: controlWord = make_cw(PSEL_FINAL, w_rd, w_rn, FSEL_ADD, 1'b1, 1'b1);
        OP_SUBI:  controlWord = make_cw(PSEL_FINAL, w_rd, w_rn, FSEL_SUB, 1'b1, 1'b0);
        OP_SUBIS: controlWord = make_cw(PSEL_FINAL, w_rd, w_rn, FSEL_SUB, 1'b1, 1'b1);
        OP_ANDI:  controlWord = make_cw(PSEL_FINAL, w_rd, w_rn, FSEL_AND, 1'b1, 1'b0);
        OP_ANDIS: controlWord = make_cw(PSEL_FINAL, w_rd, w_rn, FSEL_AND, 1'b1, 1'b1);
        OP_ORRI:  controlWord = make_cw(PSEL_FINAL, w_rd, w_rn, FSEL_ORR, 1'b1, 1'b0);
        OP_EORI:  controlWord = make_cw(PSEL_FINAL, w_rd, w_rn, FSEL_EOR, 1'b1, 1'b0);
        default: begin
          K       = '0;
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/i_imm_sequencer.sv
// Clocked immediate-class sequencer: accepts one instruction per cycle,
// issues one registered control word (two for MOVK: mask then merge).
module i_imm_sequencer
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           instruction,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [CW_W-1:0]       controlWord,
  output logic [DATA_WIDTH-1:0] K,
  output logic                  cw_valid,
  output logic                  illegal,
  output logic [1:0]            state
);

  state_t                r_state;
  state_t                w_next_state;
  logic [31:0]           r_instr;
  logic [CW_W-1:0]       r_cw_p1;
  logic [DATA_WIDTH-1:0] r_k_p1;
  logic                  r_vld_p1;
  logic                  r_ill_p1;

  logic                  w_accept;
  logic                  w_step;
  logic [31:0]           w_dec_instr;
  logic [CW_W-1:0]       w_dec_cw;
  logic [DATA_WIDTH-1:0] w_dec_k;
  logic                  w_dec_is_movk;
  logic                  w_dec_illegal;
  logic [CW_W-1:0]       w_next_cw;
  logic [DATA_WIDTH-1:0] w_next_k;
  logic                  w_next_vld;
  logic                  w_next_ill;

  assign instr_ready = reset && (r_state != ST_MOVK_MASK);
  assign w_accept    = instr_valid && instr_ready;
  // During the mask cycle the held MOVK is re-decoded for its merge step.
  assign w_step      = (r_state == ST_MOVK_MASK);
  assign w_dec_instr = w_step ? r_instr : instruction;

  i_imm_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .instruction (w_dec_instr),
    .step        (w_step),
    .controlWord (w_dec_cw),
    .K           (w_dec_k),
    .is_movk     (w_dec_is_movk),
    .illegal     (w_dec_illegal)
  );

  // Hold the accepted instruction so the MOVK merge step can be decoded later
  always_ff @(posedge clock) begin
    if (w_accept) r_instr <= instruction;
  end

  // Next state and next registered outputs; default is an idle NOP cycle
  always_comb begin
    w_next_state = ST_IDLE;
    w_next_cw    = CW_NOP;
    w_next_k     = '0;
    w_next_vld   = 1'b0;
    w_next_ill   = 1'b0;
    if (r_state == ST_MOVK_MASK) begin
      w_next_state = ST_EXEC;
      w_next_cw    = w_dec_cw;
      w_next_k     = w_dec_k;
      w_next_vld   = 1'b1;
    end else if (w_accept) begin
      if (w_dec_illegal) begin
        w_next_ill = 1'b1;
      end else begin
        w_next_state = w_dec_is_movk ? ST_MOVK_MASK : ST_EXEC;
        w_next_cw    = w_dec_cw;
        w_next_k     = w_dec_k;
        w_next_vld   = 1'b1;
      end
    end
  end

  // ---- stage p1: state and output registers ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cw_p1  <= CW_NOP;
      r_k_p1   <= '0;
      r_vld_p1 <= 1'b0;
      r_ill_p1 <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cw_p1  <= w_next_cw;
      r_k_p1   <= w_next_k;
      r_vld_p1 <= w_next_vld;
      r_ill_p1 <= w_next_ill;
    end
  end

  assign controlWord = r_cw_p1;
  assign K           = r_k_p1;
  assign cw_valid    = r_vld_p1;
  assign illegal     = r_ill_p1;
  assign state       = r_state;

endmodule
